// File: rtl/axi_monitor_pkg.sv
// Shared types for the AXI read-recovery monitor: FSM state encoding and counter widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_monitor_pkg;

  localparam int StateW  = 3;
  localparam int EvtCntW = 16;

  // Encoding is fixed so software and state_o consumers see the same values in every build.
  typedef enum logic [StateW-1:0] {
    ST_IDLE    = 3'd0,
    ST_ISOLATE = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_HOLD    = 3'd4
  } rec_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [EvtCntW-1:0] evt_sat_inc(input logic [EvtCntW-1:0] v);
    return (v == '1) ? v : v + EvtCntW'(1);
  endfunction

endpackage

// File: rtl/rd_outstanding_cnt.sv
// Saturating up/down counter of outstanding read transactions (clamps at 0 and MaxCnt).
// Latency: count reflects inc/dec/clr one cycle after the sampling edge.
// Backpressure: none; a simultaneous inc and dec cancel out.
module rd_outstanding_cnt #(
  parameter int MaxCnt = 8,
  parameter int CntW   = $clog2(MaxCnt + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CntW-1:0] cnt_o
);

  localparam logic [CntW-1:0] CntMax = CntW'(MaxCnt);

  // Clear has priority; otherwise move one step unless already at the relevant limit.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && !dec_i && (cnt_o != CntMax)) begin
      cnt_o <= cnt_o + CntW'(1);
    end else if (dec_i && !inc_i && (cnt_o != '0)) begin
      cnt_o <= cnt_o - CntW'(1);
    end
  end

endmodule

// File: rtl/rd_recovery_ctrl.sv
// Read-channel recovery sequencer: isolate AR, drain outstanding R, flush, hold; optional DRAIN via RD_RECOVERY_DRAIN_EN.
// Latency: request seen in IDLE -> ISOLATE next cycle; status outputs registered, ar_block_o/r_force_ready_o decoded from state.
// Backpressure: a stalled AR at recovery entry stays unmasked until it handshakes; DRAIN sinks R beats by forcing ready.
module rd_recovery_ctrl
  import axi_monitor_pkg::*;
#(
  parameter int MaxRdTxns   = 8,
  parameter int DrainCycles = 256,
  parameter int HoldCycles  = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               reset_req_i,
  input  logic               ar_valid_i,
  input  logic               ar_ready_i,
  input  logic               r_valid_i,
  input  logic               r_ready_i,
  input  logic               r_last_i,
  output logic               ar_block_o,
  output logic               r_force_ready_o,
  output logic               txn_rst_o,
  output logic               irq_o,
  output logic               busy_o,
  output logic               drain_to_o,
  output logic [EvtCntW-1:0] evt_cnt_o,
  output logic [StateW-1:0]  state_o
);

  localparam int OcW    = $clog2(MaxRdTxns + 1);
  // One timer serves both DRAIN and HOLD, so it is sized for the longer dwell.
  localparam int TmrMax = (DrainCycles > HoldCycles) ? DrainCycles : HoldCycles;
  localparam int TmrW   = $clog2(TmrMax + 1);
  localparam logic [TmrW-1:0] HoldLast = TmrW'(HoldCycles - 1);

  rec_state_e      state;
  rec_state_e      state_nxt;
  logic [TmrW-1:0] tmr;
  logic            ar_pend;
  logic [OcW-1:0]  oc;
  logic            ar_hs;
  logic            r_hs;
  logic            cnt_en;
  logic            start;

  // AR stays open while an AR that was stalled at entry is still waiting for its handshake.
  assign ar_block_o = (state != ST_IDLE) && !ar_pend;
  assign state_o    = state;
  assign ar_hs      = ar_valid_i && ar_ready_i;
  assign r_hs       = r_valid_i && (r_ready_i || r_force_ready_o) && r_last_i;
  assign start      = (state == ST_IDLE) && reset_req_i;
  // Traffic seen after the flush belongs to nobody we track, so it is not counted.
  assign cnt_en     = (state == ST_IDLE) || (state == ST_ISOLATE) || (state == ST_DRAIN);

  rd_outstanding_cnt #(
    .MaxCnt (MaxRdTxns),
    .CntW   (OcW)
  ) u_oc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (state == ST_FLUSH),
    .inc_i  (cnt_en && ar_hs),
    .dec_i  (cnt_en && r_hs),
    .cnt_o  (oc)
  );

`ifdef RD_RECOVERY_DRAIN_EN
  localparam logic [TmrW-1:0] DrainLast = TmrW'(DrainCycles - 1);
  logic drain_to_q;

  assign r_force_ready_o = (state == ST_DRAIN);
  assign drain_to_o      = drain_to_q;

  // Sticky flag: DRAIN gave up on its dwell limit with reads still outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drain_to_q <= 1'b0;
    end else if ((state == ST_DRAIN) && (oc != '0) && (tmr == DrainLast)) begin
      drain_to_q <= 1'b1;
    end
  end
`else
  logic unused_oc;

  assign r_force_ready_o = 1'b0;
  assign drain_to_o      = 1'b0;
  assign unused_oc       = ^oc;
`endif

  // Next-state decode; ISOLATE waits for any stalled AR to complete before moving on.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (reset_req_i) state_nxt = ST_ISOLATE;
`ifdef RD_RECOVERY_DRAIN_EN
      ST_ISOLATE: if (!ar_pend) state_nxt = ST_DRAIN;
      ST_DRAIN:   if ((oc == '0) || (tmr == DrainLast)) state_nxt = ST_FLUSH;
`else
      ST_ISOLATE: if (!ar_pend) state_nxt = ST_FLUSH;
`endif
      ST_FLUSH:   state_nxt = ST_HOLD;
      ST_HOLD:    if (tmr == HoldLast) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // State register and dwell timer; the timer restarts from 0 on every state change.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        tmr <= '0;
      end else if ((state == ST_DRAIN) || (state == ST_HOLD)) begin
        tmr <= tmr + TmrW'(1);
      end
    end
  end

  // Remember an AR that was mid-handshake when recovery began; clear once it completes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ar_pend <= 1'b0;
    end else if (start) begin
      ar_pend <= ar_valid_i && !ar_ready_i;
    end else if (ar_hs) begin
      ar_pend <= 1'b0;
    end
  end

  // Registered status: flush strobe tracks FLUSH exactly, irq and event count mark each start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      txn_rst_o <= 1'b0;
      irq_o     <= 1'b0;
      busy_o    <= 1'b0;
      evt_cnt_o <= '0;
    end else begin
      txn_rst_o <= (state_nxt == ST_FLUSH);
      irq_o     <= start;
      busy_o    <= (state_nxt != ST_IDLE);
      if (start) begin
        evt_cnt_o <= evt_sat_inc(evt_cnt_o);
      end
    end
  end

endmodule

// File: tb/tb_rd_recovery_ctrl.sv
// Self-checking bench for rd_recovery_ctrl: per-cycle comparison against a behavioural model plus directed literal checks.
// Latency: model predicts outputs after each clock edge.
// Backpressure: stimulus holds a stalled AR to exercise the unmask path.
module tb_rd_recovery_ctrl;

  localparam int MaxRdTxns   = 8;
  localparam int DrainCycles = 16;
  localparam int HoldCycles  = 4;
`ifdef RD_RECOVERY_DRAIN_EN
  localparam bit DrainEn = 1'b1;
`else
  localparam bit DrainEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        arv = 1'b0, arr = 1'b0;
  logic        rv = 1'b0, rr = 1'b0, rl = 1'b0;
  logic        ar_block, r_force, txn, irq, busy, dto;
  logic [15:0] evt;
  logic [2:0]  st;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  rd_recovery_ctrl #(
    .MaxRdTxns   (MaxRdTxns),
    .DrainCycles (DrainCycles),
    .HoldCycles  (HoldCycles)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .reset_req_i     (req),
    .ar_valid_i      (arv),
    .ar_ready_i      (arr),
    .r_valid_i       (rv),
    .r_ready_i       (rr),
    .r_last_i        (rl),
    .ar_block_o      (ar_block),
    .r_force_ready_o (r_force),
    .txn_rst_o       (txn),
    .irq_o           (irq),
    .busy_o          (busy),
    .drain_to_o      (dto),
    .evt_cnt_o       (evt),
    .state_o         (st)
  );

  // ---------------- behavioural model ----------------
  // Phases: 0 idle, 1 isolate, 2 drain, 3 flush, 4 hold. m_left counts remaining dwell cycles down.
  int m_st = 0, m_oc = 0, m_evt = 0, m_left = 0;
  bit m_pend = 0, m_irq = 0, m_txn = 0, m_dto = 0;

  always @(posedge clk) begin : model
    int ph;
    int nx;
    bit hs_ar;
    bit hs_r;
    if (rst) begin
      m_st = 0; m_oc = 0; m_evt = 0; m_left = 0;
      m_pend = 0; m_irq = 0; m_txn = 0; m_dto = 0;
    end else begin
      ph    = m_st;
      nx    = ph;
      hs_ar = arv && arr;
      hs_r  = rv && (rr || (DrainEn && ph == 2)) && rl;
      m_irq = 0;
      case (ph)
        0: if (req) begin
             nx = 1; m_irq = 1;
             if (m_evt < 65535) m_evt = m_evt + 1;
           end
        1: if (!m_pend) begin
             nx = DrainEn ? 2 : 3;
             m_left = DrainCycles;
           end
        2: if (m_oc == 0) nx = 3;
           else if (m_left == 1) begin nx = 3; m_dto = 1; end
           else m_left = m_left - 1;
        3: begin nx = 4; m_left = HoldCycles; end
        default: if (m_left == 1) nx = 0; else m_left = m_left - 1;
      endcase
      if (ph == 0 && req) m_pend = arv && !arr;
      else if (hs_ar) m_pend = 0;
      if (ph == 3) m_oc = 0;
      else if (ph <= 2) begin
        m_oc = m_oc + int'(hs_ar) - int'(hs_r);
        if (m_oc > MaxRdTxns) m_oc = MaxRdTxns;
        if (m_oc < 0) m_oc = 0;
      end
      m_st  = nx;
      m_txn = (nx == 3);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    logic [33:0] got;
    logic [33:0] exp;
    if (chk_en) begin
      got = {st, busy, irq, txn, dto, ar_block, r_force, evt, 8'(dut.oc)};
      exp = {3'(m_st), m_st != 0, m_irq, m_txn, DrainEn && m_dto,
             (m_st != 0) && !m_pend, DrainEn && (m_st == 2), 16'(m_evt), 8'(m_oc)};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL cycle_model t=%0t got {st,busy,irq,txn,dto,arblk,rfr,evt,oc}=%h expected %h",
                 $time, got, exp);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic idle_in();
    req = 0; arv = 0; arr = 0; rv = 0; rr = 0; rl = 0;
  endtask

  initial begin : watchdog
    #200000;
    fails++;
    $display("FAIL watchdog: simulation exceeded time budget");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin : main
    int t_flush;
    int t_idle;
    int n_txn;

    idle_in();
    rst = 1;
    step(2);
    chk_en = 1;
    check("reset_state", int'(st), 0);
    check("reset_evt", int'(evt), 0);
    check("reset_busy", int'(busy), 0);
    rst = 0;

    // Three ARs, one request, R last beats in DRAIN cycles 4/6/8.
    repeat (3) begin arv = 1; arr = 1; step(); end
    idle_in();
    check("A_oc_3", int'(dut.oc), 3);
    req = 1; step(); req = 0;
    check("A_irq", int'(irq), 1);
    check("A_isolate", int'(st), 1);
    check("A_evt", int'(evt), 1);
    t_flush = -1; t_idle = -1; n_txn = 0;
    for (int i = 1; i <= 24; i++) begin
      if (txn) begin n_txn++; if (t_flush < 0) t_flush = i; end
      if (st == 3'd0 && t_idle < 0) t_idle = i;
      rv = (i == 6 || i == 8 || i == 10); rr = rv; rl = rv;
      step();
    end
    idle_in();
    check("A_flush_cycle", t_flush, DrainEn ? 12 : 2);
    check("A_txn_pulses", n_txn, 1);
    check("A_idle_cycle", t_idle, DrainEn ? 17 : 7);

    // OC=2, no R beats: DRAIN runs its full dwell and times out.
    repeat (2) begin arv = 1; arr = 1; step(); end
    idle_in();
    req = 1; step(); req = 0;
    t_flush = -1;
    for (int i = 1; i <= 30; i++) begin
      if (txn && t_flush < 0) t_flush = i;
      step();
    end
    check("B_flush_cycle", t_flush, DrainEn ? 18 : 2);
    check("B_drain_to", int'(dto), int'(DrainEn));
    check("B_evt", int'(evt), 2);
    check("B_idle", int'(st), 0);

    // Stalled AR at request time stays unmasked until it completes.
    arv = 1; arr = 0; req = 1; step(); req = 0;
    for (int i = 0; i < 3; i++) begin
      check("C_unmasked", int'(ar_block), 0);
      check("C_isolate", int'(st), 1);
      step();
    end
    arr = 1; step(); idle_in();
    check("C_masked", int'(ar_block), 1);
    check("C_oc", int'(dut.oc), 1);
    step(40);
    check("C_idle", int'(st), 0);
    check("C_evt", int'(evt), 3);

    // Reset in the middle of a recovery.
    arv = 1; arr = 1; step(); idle_in();
    req = 1; step(); req = 0;
    n_txn = 0;
    for (int i = 1; i <= 2; i++) begin
      step();
      if (txn) n_txn++;
    end
    check("D_mid_state", int'(st), DrainEn ? 2 : 4);
    rst = 1; step(); rst = 0;
    check("D_txn_before", n_txn, DrainEn ? 0 : 1);
    check("D_state", int'(st), 0);
    check("D_busy", int'(busy), 0);
    check("D_evt", int'(evt), 0);
    check("D_txn", int'(txn), 0);
    check("D_drain_to", int'(dto), 0);
    check("D_oc", int'(dut.oc), 0);

    // Counter saturation at both ends.
    repeat (10) begin arv = 1; arr = 1; step(); end
    idle_in();
    check("E_oc_sat", int'(dut.oc), 8);
    check("E_model_sat", m_oc, 8);
    arv = 1; arr = 1; rv = 1; rr = 1; rl = 1; step(); idle_in();
    check("E_oc_both", int'(dut.oc), 8);
    rv = 1; rr = 1; rl = 1; step(); idle_in();
    check("E_oc_dec", int'(dut.oc), 7);
    rv = 1; rr = 1; rl = 0; step(); idle_in();
    check("E_oc_notlast", int'(dut.oc), 7);
    repeat (9) begin rv = 1; rr = 1; rl = 1; step(); end
    idle_in();
    check("E_oc_floor", int'(dut.oc), 0);

    // Request held across HOLD->IDLE with continuous AR traffic.
    req = 1; arv = 1; arr = 1; step();
    t_idle = -1;
    for (int i = 1; i <= 40; i++) begin
      if (t_idle > 0 && i == t_idle + 1) begin
        check("G_restart_state", int'(st), 1);
        check("G_restart_irq", int'(irq), 1);
      end
      if (st == 3'd0 && t_idle < 0) t_idle = i;
      step();
    end
    idle_in();
    check("G_idle_cycle", t_idle, DrainEn ? 23 : 7);
    step(40);
    check("G_final_idle", int'(st), 0);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
